// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int WORD_W     = 32;
    localparam int BLOCK_W    = 128;
    localparam int OFFSET_W   = 2;
    localparam int BLK_ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    function automatic int index_w(input int num_blocks);
        return $clog2(num_blocks);
    endfunction

    function automatic int tag_w(input int num_blocks);
        return BLK_ADDR_W - $clog2(num_blocks);
    endfunction

    function automatic logic [WORD_W-1:0] line_word(input logic [BLOCK_W-1:0] line,
                                                     input logic [OFFSET_W-1:0] off);
        return line[int'(off)*WORD_W +: WORD_W];
    endfunction

    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// CPU-side and memory-side handshake bundle of the data cache.
interface dcache_responder_if;
    import dcache_pkg::*;

    logic                  cpu_read;
    logic                  cpu_write;
    logic [WORD_W-1:0]     cpu_addr;
    logic [WORD_W-1:0]     cpu_wdata;
    logic [WORD_W-1:0]     cpu_rdata;
    logic                  cpu_ready;
    logic                  mem_read;
    logic                  mem_write;
    logic [BLK_ADDR_W-1:0] mem_addr;
    logic [BLOCK_W-1:0]    mem_wdata;
    logic [BLOCK_W-1:0]    mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage for the cache lines: one combinational read port,
// one write port with line-fill, word-write and dirty-set enables.
module dcache_array
    import dcache_pkg::*;
#(
    parameter  int NUM_BLOCKS = 8,
    localparam int IDX_W      = index_w(NUM_BLOCKS),
    localparam int TAG_W      = tag_w(NUM_BLOCKS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rd_index,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [BLOCK_W-1:0]  rd_line,
    input  logic [IDX_W-1:0]    wr_index,
    input  logic                fill_en,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_line,
    input  logic                word_en,
    input  logic [OFFSET_W-1:0] word_off,
    input  logic [WORD_W-1:0]   word_data,
    input  logic                dirty_set_en
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] valid_d;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [NUM_BLOCKS-1:0] dirty_d;
    logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_mem [NUM_BLOCKS];

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];

    // A fill always leaves the line clean; a store marks it dirty.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_en) begin
            valid_d[wr_index] = 1'b1;
            dirty_d[wr_index] = 1'b0;
        end else if (dirty_set_en) begin
            dirty_d[wr_index] = 1'b1;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Line state flops; reset invalidates every line and drops dirty data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= {NUM_BLOCKS{1'b0}};
            dirty_q <= {NUM_BLOCKS{1'b0}};
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[wr_index]  <= fill_tag;
            data_mem[wr_index] <= fill_line;
        end else if (word_en) begin
            data_mem[wr_index][int'(word_off)*WORD_W +: WORD_W] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic              clk,
    input  logic              rst,
    dcache_responder_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [WORD_W-1:0] hit_cnt,
    output logic [WORD_W-1:0] miss_cnt
`endif
);

    localparam int IDX_W  = index_w(NUM_BLOCKS);
    localparam int TAG_W  = tag_w(NUM_BLOCKS);
    localparam int LINE_W = WORDS_PER_BLOCK * WORD_W;

    logic [OFFSET_W-1:0]   req_off_s;
    logic [IDX_W-1:0]      req_index_s;
    logic [TAG_W-1:0]      req_tag_s;
    logic [BLK_ADDR_W-1:0] req_blk_s;
    logic                  unused_byte_sel_s;
    logic                  req_s;
    logic                  hit_s;
    logic                  rd_valid_s;
    logic                  rd_dirty_s;
    logic [TAG_W-1:0]      rd_tag_s;
    logic [BLOCK_W-1:0]    rd_line_s;
    logic                  fill_en_s;
    logic                  word_en_s;
    logic                  dirty_set_s;
    logic                  cpu_ready_s;
    logic [WORD_W-1:0]     cpu_rdata_s;

    state_e                state_q;
    state_e                state_d;
    logic                  mem_read_q;
    logic                  mem_read_d;
    logic                  mem_write_q;
    logic                  mem_write_d;
    logic [BLK_ADDR_W-1:0] mem_addr_q;
    logic [BLK_ADDR_W-1:0] mem_addr_d;
    logic [LINE_W-1:0]     mem_wdata_q;
    logic [LINE_W-1:0]     mem_wdata_d;

    assign req_off_s         = bus.cpu_addr[3:2];
    assign req_index_s       = bus.cpu_addr[4 +: IDX_W];
    assign req_tag_s         = bus.cpu_addr[31 -: TAG_W];
    assign req_blk_s         = bus.cpu_addr[31:4];
    assign unused_byte_sel_s = ^bus.cpu_addr[1:0];

    dcache_array #(
        .NUM_BLOCKS(NUM_BLOCKS)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .rd_index     (req_index_s),
        .rd_valid     (rd_valid_s),
        .rd_dirty     (rd_dirty_s),
        .rd_tag       (rd_tag_s),
        .rd_line      (rd_line_s),
        .wr_index     (req_index_s),
        .fill_en      (fill_en_s),
        .fill_tag     (req_tag_s),
        .fill_line    (bus.mem_rdata),
        .word_en      (word_en_s),
        .word_off     (req_off_s),
        .word_data    (bus.cpu_wdata),
        .dirty_set_en (dirty_set_s)
    );

    // Hit detection against the line selected by the request index.
    always_comb begin
        req_s = bus.cpu_read | bus.cpu_write;
        hit_s = req_s & rd_valid_s & (rd_tag_s == req_tag_s);
    end

    // Zero-wait response: ready only from IDLE, load data only for pure reads.
    always_comb begin
        cpu_ready_s = 1'b0;
        cpu_rdata_s = {WORD_W{1'b0}};
        if ((state_q == IDLE) && hit_s) begin
            cpu_ready_s = 1'b1;
            cpu_rdata_s = bus.cpu_write ? {WORD_W{1'b0}} : line_word(rd_line_s, req_off_s);
        end else begin
            cpu_ready_s = 1'b0;
        end
    end

    // Next-state and memory-side request computation.
    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_en_s   = 1'b0;
        word_en_s   = 1'b0;
        dirty_set_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit_s) begin
                    word_en_s   = bus.cpu_write;
                    dirty_set_s = bus.cpu_write;
                end else if (req_s && rd_valid_s && rd_dirty_s) begin
                    state_d     = WRITEBACK;
                    mem_write_d = 1'b1;
                    mem_addr_d  = {rd_tag_s, req_index_s};
                    mem_wdata_d = rd_line_s;
                end else if (req_s) begin
                    state_d    = ALLOCATE;
                    mem_read_d = 1'b1;
                    mem_addr_d = req_blk_s;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITEBACK: begin
                if (bus.mem_ready) begin
                    state_d     = ALLOCATE;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = req_blk_s;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            ALLOCATE: begin
                // The held request replays in IDLE next cycle and hits the new line.
                if (bus.mem_ready) begin
                    state_d    = IDLE;
                    mem_read_d = 1'b0;
                    fill_en_s  = 1'b1;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // Controller state and registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {BLK_ADDR_W{1'b0}};
            mem_wdata_q <= {LINE_W{1'b0}};
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.cpu_ready = cpu_ready_s;
    assign bus.cpu_rdata = cpu_rdata_s;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    logic              after_alloc_q;
    logic              after_alloc_d;
    logic [WORD_W-1:0] hit_cnt_q;
    logic [WORD_W-1:0] hit_cnt_d;
    logic [WORD_W-1:0] miss_cnt_q;
    logic [WORD_W-1:0] miss_cnt_d;

    // The replay hit right after a fill is part of the miss, not a new hit.
    always_comb begin
        after_alloc_d = (state_q == ALLOCATE) && bus.mem_ready;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        if ((state_q == IDLE) && hit_s && !after_alloc_q) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if ((state_q == IDLE) && req_s && !hit_s) begin
            miss_cnt_d = sat_inc(miss_cnt_q);
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Statistics counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            after_alloc_q <= 1'b0;
            hit_cnt_q     <= 32'd0;
            miss_cnt_q    <= 32'd0;
        end else begin
            after_alloc_q <= after_alloc_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
